// File: rtl/dmx8_pkg.sv
// Shared constants and types for the 8-slot, 4-bit routed register bank.
// The data width and slot count are set here and used by every other file.
package dmx8_pkg;

    localparam int DATA_W = 4;
    localparam int SLOTS  = 8;
    localparam int SEL_W  = $clog2(SLOTS);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [SLOTS-1:0]  slot_mask_t;

endpackage

// File: rtl/dmx8.sv
// Combinational 1-to-8 demux: steers the write strobe onto the enable line
// of the slot selected by {s2,s1,s0}.
module dmx8
    import dmx8_pkg::*;
(
    input  logic       we,
    input  logic       s2,
    input  logic       s1,
    input  logic       s0,
    output slot_mask_t en
);

    sel_t sel;

    assign sel = {s2, s1, s0};

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_en
            assign en[gi] = we && (sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/dmx8_4bits_reg.sv
// Eight 4-bit registered slots with per-slot valid flags. A write goes either
// to the explicit select or, in auto mode, to a wrapping write pointer.
module dmx8_4bits_reg
    import dmx8_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    input  logic              s2,
    input  logic              s1,
    input  logic              s0,
    input  logic              we,
    input  logic              auto,
    input  logic              clr,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y3,
    output logic [DATA_W-1:0] y4,
    output logic [DATA_W-1:0] y5,
    output logic [DATA_W-1:0] y6,
    output logic [DATA_W-1:0] y7,
    output logic [SLOTS-1:0]  vld,
    output logic [SEL_W-1:0]  ptr,
    output logic              full
);

    sel_t       target;
    slot_mask_t slot_en;
    logic       wr_ok;

    data_t      slot_reg [SLOTS];
    slot_mask_t vld_reg;
    slot_mask_t vld_next;
    sel_t       ptr_reg;
    sel_t       ptr_next;

    // clr takes priority over a simultaneous write: nothing is loaded.
    assign wr_ok  = we && !clr;
    assign target = auto ? ptr_reg : {s2, s1, s0};

    dmx8 u_dmx8 (
        .we (wr_ok),
        .s2 (target[2]),
        .s1 (target[1]),
        .s0 (target[0]),
        .en (slot_en)
    );

    always_comb begin
        ptr_next = ptr_reg;
        vld_next = vld_reg | slot_en;
        if (clr) begin
            ptr_next = '0;
            vld_next = '0;
        end else if (we && auto) begin
            ptr_next = ptr_reg + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
            vld_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            vld_reg <= vld_next;
        end
    end

    // Slot data survives clr; only reset wipes it.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot_reg[gi] <= '0;
                end else if (slot_en[gi]) begin
                    slot_reg[gi] <= d;
                end
            end
        end
    endgenerate

    assign y0   = slot_reg[0];
    assign y1   = slot_reg[1];
    assign y2   = slot_reg[2];
    assign y3   = slot_reg[3];
    assign y4   = slot_reg[4];
    assign y5   = slot_reg[5];
    assign y6   = slot_reg[6];
    assign y7   = slot_reg[7];
    assign vld  = vld_reg;
    assign ptr  = ptr_reg;
    assign full = &vld_reg;

endmodule

// File: tb/tb_dmx8_4bits_reg.sv
// Directed bench for dmx8_4bits_reg: hand-computed expectations checked with
// immediate assertions after each step.
module tb_dmx8_4bits_reg;

    logic       clk;
    logic       reset;
    logic [3:0] d;
    logic       s2, s1, s0;
    logic       we, auto, clr;
    logic [3:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic [7:0] vld;
    logic [2:0] ptr;
    logic       full;

    int checks = 0;
    int fails  = 0;

    dmx8_4bits_reg dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .s2    (s2),
        .s1    (s1),
        .s0    (s0),
        .we    (we),
        .auto  (auto),
        .clr   (clr),
        .y0    (y0),
        .y1    (y1),
        .y2    (y2),
        .y3    (y3),
        .y4    (y4),
        .y5    (y5),
        .y6    (y6),
        .y7    (y7),
        .vld   (vld),
        .ptr   (ptr),
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] get_y(input int i);
        case (i)
            0: return y0;
            1: return y1;
            2: return y2;
            3: return y3;
            4: return y4;
            5: return y5;
            6: return y6;
            default: return y7;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
        $display("check %-14s got %h expected %h", tag, obs, exp);
    endtask

    // One write cycle; inputs change 1 time unit after the active edge.
    task automatic wr(input logic [3:0] dd, input logic [2:0] sel,
                      input logic a, input logic c);
        d = dd;
        {s2, s1, s0} = sel;
        auto = a;
        clr = c;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        d = 4'h0;
        {s2, s1, s0} = 3'd0;
        we = 1'b0;
        auto = 1'b0;
        clr = 1'b0;

        #12;
        check("rst_y0", {4'h0, y0}, 8'h00);
        check("rst_y7", {4'h0, y7}, 8'h00);
        check("rst_vld", vld, 8'h00);
        check("rst_ptr", {5'd0, ptr}, 8'd0);
        check("rst_full", {7'd0, full}, 8'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // explicit-select writes
        wr(4'hA, 3'd3, 1'b0, 1'b0);
        check("sel_lat_y3", {4'h0, y3}, 8'h0A);
        wr(4'h5, 3'd7, 1'b0, 1'b0);
        check("sel_y3", {4'h0, y3}, 8'h0A);
        check("sel_y7", {4'h0, y7}, 8'h05);
        check("sel_vld", vld, 8'h88);
        check("sel_full", {7'd0, full}, 8'd0);
        check("sel_ptr", {5'd0, ptr}, 8'd0);

        // we low with busy inputs: nothing moves
        for (int k = 0; k < 10; k++) begin
            d = 4'($urandom);
            {s2, s1, s0} = 3'($urandom);
            auto = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("idle_y3", {4'h0, y3}, 8'h0A);
        check("idle_y7", {4'h0, y7}, 8'h05);
        check("idle_y0", {4'h0, y0}, 8'h00);
        check("idle_vld", vld, 8'h88);
        check("idle_ptr", {5'd0, ptr}, 8'd0);

        // auto fill, explicit select deliberately pointing elsewhere
        for (int i = 0; i < 4; i++) wr(4'(i), 3'(7 - i), 1'b1, 1'b0);
        check("auto4_ptr", {5'd0, ptr}, 8'd4);
        check("auto4_vld", vld, 8'h8F);
        check("auto4_full", {7'd0, full}, 8'd0);
        for (int i = 4; i < 8; i++) wr(4'(i), 3'(7 - i), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("auto_y%0d", i), {4'h0, get_y(i)}, 8'(i));
        check("auto_vld", vld, 8'hFF);
        check("auto_full", {7'd0, full}, 8'd1);
        check("auto_ptr", {5'd0, ptr}, 8'd0);

        // write while full: overwrite, no blocking
        wr(4'hF, 3'd5, 1'b1, 1'b0);
        check("ovr_y0", {4'h0, y0}, 8'h0F);
        check("ovr_y1", {4'h0, y1}, 8'h01);
        check("ovr_vld", vld, 8'hFF);
        check("ovr_ptr", {5'd0, ptr}, 8'd1);

        // clr beats a simultaneous write
        wr(4'h9, 3'd1, 1'b1, 1'b1);
        check("clr_vld", vld, 8'h00);
        check("clr_ptr", {5'd0, ptr}, 8'd0);
        check("clr_y0", {4'h0, y0}, 8'h0F);
        check("clr_y1", {4'h0, y1}, 8'h01);
        check("clr_full", {7'd0, full}, 8'd0);

        // explicit write does not move ptr; toggling auto alone does not either
        wr(4'hC, 3'd5, 1'b0, 1'b0);
        check("man_y5", {4'h0, y5}, 8'h0C);
        check("man_vld", vld, 8'h20);
        check("man_ptr", {5'd0, ptr}, 8'd0);
        auto = 1'b1;
        @(posedge clk);
        #1;
        auto = 1'b0;
        @(posedge clk);
        #1;
        check("tog_ptr", {5'd0, ptr}, 8'd0);

        // asynchronous reset mid-sequence
        wr(4'h1, 3'd0, 1'b1, 1'b0);
        wr(4'h2, 3'd0, 1'b1, 1'b0);
        wr(4'h3, 3'd0, 1'b1, 1'b0);
        check("pre_ptr", {5'd0, ptr}, 8'd3);
        check("pre_vld", vld, 8'h27);
        #2;
        reset = 1'b1;
        #1;
        check("arst_y0", {4'h0, y0}, 8'h00);
        check("arst_y2", {4'h0, y2}, 8'h00);
        check("arst_y5", {4'h0, y5}, 8'h00);
        check("arst_vld", vld, 8'h00);
        check("arst_ptr", {5'd0, ptr}, 8'd0);
        check("arst_full", {7'd0, full}, 8'd0);
        d = 4'hE;
        auto = 1'b1;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        check("rstwe_y0", {4'h0, y0}, 8'h00);
        check("rstwe_vld", vld, 8'h00);
        check("rstwe_ptr", {5'd0, ptr}, 8'd0);
        reset = 1'b0;
        wr(4'h7, 3'd5, 1'b1, 1'b0);
        check("post_y0", {4'h0, y0}, 8'h07);
        check("post_y5", {4'h0, y5}, 8'h00);
        check("post_vld", vld, 8'h01);
        check("post_ptr", {5'd0, ptr}, 8'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
